// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the forwarder round-robin arbiter.
package fwd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } fwd_arb_state_t;

    // Packet length needs one extra bit so a full buffer's length is representable.
    function automatic int plen_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    logic found;
    int   p;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        p          = 0;
        for (int i = 1; i <= N_PORTS; i++) begin
            p = (int'(ptr) + i) % N_PORTS;
            if (!found && req[p]) begin
                found      = 1'b1;
                winner[p]  = 1'b1;
                winner_idx = IDX_W'(p);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fwd_rr_arbiter.sv
// N-way round-robin arbiter sharing one packet forwarder among N BPFVM buffers.
// The grant stays locked from selection until the forwarder's done pulse or a withdraw.
module fwd_rr_arbiter
    import fwd_pkg::*;
#(
    parameter int  N_PORTS    = 4,
    parameter int  DATA_WIDTH = 64,
    parameter int  ADDR_WIDTH = 10,
    localparam int PLEN_WIDTH = plen_width(ADDR_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORTS-1:0]               ready_for_forwarder_i,
    input  logic [N_PORTS*PLEN_WIDTH-1:0]    len_to_forwarder_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    forwarder_rd_data_i,
    output logic [ADDR_WIDTH-1:0]            forwarder_rd_addr_o,
    output logic [N_PORTS-1:0]               forwarder_rd_en_o,
    output logic [N_PORTS-1:0]               forwarder_done_o,
    input  logic [ADDR_WIDTH-1:0]            forwarder_rd_addr,
    input  logic                             forwarder_rd_en,
    input  logic                             forwarder_done,
    output logic                             ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]            len_to_forwarder,
    output logic [DATA_WIDTH-1:0]            forwarder_rd_data,
    output logic [N_PORTS-1:0]               grant_o
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    fwd_arb_state_t     state, state_nxt;
    logic [N_PORTS-1:0] grant_q;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;

    logic [N_PORTS-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               release_g;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (ready_for_forwarder_i),
        .ptr        (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    // Done wins over a simultaneous withdraw; both release the grant the same way.
    assign release_g = forwarder_done | ~ready_for_forwarder_i[gidx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = GRANTED;
            GRANTED: if (release_g) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Last winner starts at N_PORTS-1 so port 0 has first priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= IDX_W'(N_PORTS - 1);
        end else if (state == IDLE) begin
            if (any_req) begin
                grant_q <= win_oh;
                gidx    <= win_idx;
            end
        end else if (release_g) begin
            grant_q <= '0;
            ptr     <= gidx;
        end
    end

    always_comb begin
        ready_for_forwarder = 1'b0;
        len_to_forwarder    = '0;
        forwarder_rd_data   = '0;
        forwarder_rd_en_o   = '0;
        forwarder_done_o    = '0;
        if (state == GRANTED) begin
            ready_for_forwarder     = ready_for_forwarder_i[gidx];
            len_to_forwarder        = len_to_forwarder_i[int'(gidx)*PLEN_WIDTH +: PLEN_WIDTH];
            forwarder_rd_data       = forwarder_rd_data_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            forwarder_rd_en_o[gidx] = forwarder_rd_en;
            forwarder_done_o[gidx]  = forwarder_done;
        end
    end

    assign forwarder_rd_addr_o = forwarder_rd_addr;
    assign grant_o             = grant_q;

endmodule

// File: tb/tb_fwd_rr_arbiter.sv
// Randomized bench for fwd_rr_arbiter against a cycle-level reference model.
module tb_fwd_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int PW = AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rdy_i;
    logic [N*PW-1:0] len_i;
    logic [N*DW-1:0] dat_i;
    logic [AW-1:0]   rd_addr_o;
    logic [N-1:0]    rd_en_o;
    logic [N-1:0]    done_o;
    logic [AW-1:0]   f_addr;
    logic            f_en;
    logic            f_done;
    logic            f_ready;
    logic [PW-1:0]   f_len;
    logic [DW-1:0]   f_data;
    logic [N-1:0]    grant;

    int checks = 0;
    int errors = 0;

    // Reference model: is a port granted, which one, and who won last.
    bit m_gr;
    int m_g;
    int m_ptr;

    always #5 clk = ~clk;

    fwd_rr_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ready_for_forwarder_i (rdy_i),
        .len_to_forwarder_i    (len_i),
        .forwarder_rd_data_i   (dat_i),
        .forwarder_rd_addr_o   (rd_addr_o),
        .forwarder_rd_en_o     (rd_en_o),
        .forwarder_done_o      (done_o),
        .forwarder_rd_addr     (f_addr),
        .forwarder_rd_en       (f_en),
        .forwarder_done        (f_done),
        .ready_for_forwarder   (f_ready),
        .len_to_forwarder      (f_len),
        .forwarder_rd_data     (f_data),
        .grant_o               (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gr  = 1'b0;
        m_g   = 0;
        m_ptr = N - 1;
    endtask

    // Compare every output against the model, then advance the model one clock.
    task automatic step();
        logic [N-1:0] oh;
        @(negedge clk);
        oh = m_gr ? (N'(1) << m_g) : '0;
        chk("grant",   64'(grant),   64'(oh));
        chk("ready",   64'(f_ready), m_gr ? 64'(rdy_i[m_g]) : 64'd0);
        chk("len",     64'(f_len),   m_gr ? 64'(len_i[m_g*PW +: PW]) : 64'd0);
        chk("data",    f_data,       m_gr ? dat_i[m_g*DW +: DW] : 64'd0);
        chk("rd_en_o", 64'(rd_en_o), (m_gr && f_en)   ? 64'(oh) : 64'd0);
        chk("done_o",  64'(done_o),  (m_gr && f_done) ? 64'(oh) : 64'd0);
        chk("rd_addr", 64'(rd_addr_o), 64'(f_addr));
        if (!m_gr) begin
            for (int k = 1; k <= N; k++) begin
                if (rdy_i[(m_ptr + k) % N]) begin
                    m_g  = (m_ptr + k) % N;
                    m_gr = 1'b1;
                    break;
                end
            end
        end else if (f_done || !rdy_i[m_g]) begin
            m_ptr = m_g;
            m_gr  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        rdy_i  = '0;
        len_i  = '0;
        dat_i  = '0;
        f_addr = '0;
        f_en   = 1'b0;
        f_done = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ready", 64'(f_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T2 fairness: all ready, done after 8 reads each.
        for (int k = 0; k < N; k++) len_i[k*PW +: PW] = PW'(16 + k);
        rdy_i = '1;
        step();
        for (int pkt = 0; pkt < 5; pkt++) begin
            chk("t2_order", 64'(grant), 64'(4'b0001 << (pkt % 4)));
            f_en = 1'b1;
            repeat (8) step();
            f_en   = 1'b0;
            f_done = 1'b1;
            step();
            f_done = 1'b0;
            chk("t2_gap", 64'(f_ready), 64'd0);
            step();
        end

        // T4 withdraw: port1 now granted with 1 and 3 requesting.
        rdy_i = 4'b1010;
        chk("t4_grant1", 64'(grant), 64'b0010);
        repeat (3) step();
        rdy_i = 4'b1000;
        step();
        step();
        chk("t4_grant3", 64'(grant), 64'b1000);

        // T3 data mux on port3.
        for (int k = 0; k < N; k++) dat_i[k*DW +: DW] = 64'hA0 + 64'(k);
        f_addr = 10'h005;
        #1;
        chk("t3_data", f_data, 64'hA3);
        chk("t3_addr", 64'(rd_addr_o), 64'h5);
        step();
        f_done = 1'b1;
        step();
        f_done = 1'b0;
        rdy_i  = '0;
        step();

        // T1 single request on port2.
        len_i[2*PW +: PW] = PW'(64);
        rdy_i = 4'b0100;
        step();
        chk("t1_ready", 64'(f_ready), 64'd1);
        chk("t1_len", 64'(f_len), 64'd64);
        f_en = 1'b1;
        #1;
        chk("t1_rd_en", 64'(rd_en_o), 64'b0100);
        step();
        f_en   = 1'b0;
        f_done = 1'b1;
        #1;
        chk("t1_done", 64'(done_o), 64'b0100);
        step();
        f_done = 1'b0;
        chk("t1_done_1cyc", 64'(done_o), 64'd0);
        rdy_i = '0;
        step();

        // T6 spurious done/rd_en while idle.
        f_en   = 1'b1;
        f_done = 1'b1;
        repeat (3) step();
        chk("t6_state", 64'(grant), 64'd0);
        f_en   = 1'b0;
        f_done = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) < 2) rdy_i[k] = ~rdy_i[k];
                len_i[k*PW +: PW] = PW'($urandom);
                dat_i[k*DW +: DW] = {$urandom, $urandom};
            end
            f_addr = AW'($urandom);
            f_en   = 1'($urandom);
            f_done = ($urandom_range(0, 7) == 0);
            step();
        end
        f_done = 1'b0;
        f_en   = 1'b1;

        // T5 reset mid-packet, then port0 wins first.
        rdy_i = '1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_ready", 64'(f_ready), 64'd0);
        chk("t5_rd_en", 64'(rd_en_o), 64'd0);
        chk("t5_data", f_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("t5_port0", 64'(grant), 64'b0001);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
